// File: rtl/tt_arith_pkg.sv
// Shared types and constants for the tile arithmetic pipeline.
// Width-dependent constants are derived from the defaults below.
package tt_arith_pkg;

    typedef enum logic [1:0] {
        MODE_ADD     = 2'b00,
        MODE_SUB     = 2'b01,
        MODE_ACC     = 2'b10,
        MODE_ACC_SAT = 2'b11
    } mode_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

    localparam logic [DEF_WIDTH-1:0] DEF_ONES    = {DEF_WIDTH{1'b1}};
    localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = {DEF_CNT_W{1'b1}};

endpackage

// File: rtl/tt_arith_core.sv
// Combinational datapath: add, subtract, accumulate, saturating accumulate.
module tt_arith_core
    import tt_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] acc_i,
    input  mode_e            mode_i,
    output logic [WIDTH-1:0] nxt_o,
    output logic             carry_o,
    output logic             sat_o
);

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic [WIDTH:0] add_s;
    logic [WIDTH:0] sub_s;
    logic [WIDTH:0] acc_s;

    assign add_s = {1'b0, a_i} + {1'b0, b_i};
    // Top bit of the extended difference is the borrow (a < b).
    assign sub_s = {1'b0, a_i} - {1'b0, b_i};
    assign acc_s = {1'b0, a_i} + {1'b0, acc_i};

    always_comb begin
        nxt_o   = add_s[WIDTH-1:0];
        carry_o = add_s[WIDTH];
        sat_o   = 1'b0;
        unique case (mode_i)
            MODE_ADD: begin
                nxt_o   = add_s[WIDTH-1:0];
                carry_o = add_s[WIDTH];
            end
            MODE_SUB: begin
                nxt_o   = sub_s[WIDTH-1:0];
                carry_o = sub_s[WIDTH];
            end
            MODE_ACC: begin
                nxt_o   = acc_s[WIDTH-1:0];
                carry_o = acc_s[WIDTH];
            end
            MODE_ACC_SAT: begin
                if (acc_s[WIDTH]) begin
                    nxt_o   = ONES;
                    carry_o = 1'b1;
                    sat_o   = 1'b1;
                end else begin
                    nxt_o   = acc_s[WIDTH-1:0];
                    carry_o = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: rtl/tt_arith_pipe.sv
// Registered arithmetic unit with valid/ready handshake, accumulator
// and saturating accumulate-event counter.
module tt_arith_pipe
    import tt_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             clear_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             sat,
    output logic [CNT_W-1:0] acc_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             is_acc;
    mode_e            mode_m;
    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH-1:0] core_nxt;
    logic             core_carry;
    logic             core_sat;

    assign mode_m   = mode_e'(mode);
    assign is_acc   = mode[1];
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // A clear in the same cycle makes the accepted beat start from zero.
    assign acc_eff  = clear_acc ? '0 : acc_q;

    tt_arith_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i     (a),
        .b_i     (b),
        .acc_i   (acc_eff),
        .mode_i  (mode_m),
        .nxt_o   (core_nxt),
        .carry_o (core_carry),
        .sat_o   (core_sat)
    );

    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        carry_d = carry_q;
        sat_d   = sat_q;
        acc_d   = acc_eff;
        cnt_d   = clear_acc ? '0 : cnt_q;
        if (accept) begin
            valid_d = 1'b1;
            res_d   = core_nxt;
            carry_d = core_carry;
            sat_d   = core_sat;
            if (is_acc) begin
                acc_d = core_nxt;
                if (clear_acc) begin
                    cnt_d = CNT_ONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sat_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            sat_q   <= sat_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign result    = res_q;
    assign carry     = carry_q;
    assign sat       = sat_q;
    assign acc_count = cnt_q;

endmodule

// File: tb/tb_tt_arith_pipe.sv
// Scoreboard bench for tt_arith_pipe against an arithmetic reference model.
module tb_tt_arith_pipe;

    localparam int W    = 8;
    localparam int CW   = 4;
    localparam int MOD  = 1 << W;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    mode;
    logic          clear_acc;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          carry;
    logic          sat;
    logic [CW-1:0] acc_count;

    typedef struct {
        int res;
        int cy;
        int st;
    } beat_t;

    beat_t q[$];
    int    tests = 0;
    int    fails = 0;
    int    m_acc = 0;
    int    m_cnt = 0;
    bit    m_valid = 0;

    tt_arith_pipe #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .clear_acc (clear_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .sat       (sat),
        .acc_count (acc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic beat_t model(input int md, input int va,
                                    input int vb, input int base);
        beat_t r;
        int s;
        r.st = 0;
        case (md)
            0: begin
                s = va + vb;
                r.res = s % MOD;
                r.cy = (s >= MOD);
            end
            1: begin
                r.res = (va - vb + MOD) % MOD;
                r.cy = (va < vb);
            end
            2: begin
                s = base + va;
                r.res = s % MOD;
                r.cy = (s >= MOD);
            end
            default: begin
                s = base + va;
                if (s >= MOD) begin
                    r.res = MOD - 1;
                    r.cy = 1;
                    r.st = 1;
                end else begin
                    r.res = s;
                    r.cy = 0;
                end
            end
        endcase
        return r;
    endfunction

    // Monitor: consumed beats pop; stalled beats must match the head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("result", int'(result), q[0].res);
                check("carry", int'(carry), q[0].cy);
                check("sat", int'(sat), q[0].st);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // Drive one cycle; inputs applied just after posedge.
    task automatic step(input bit v, input int md, input int va,
                        input int vb, input bit clr, input bit ordy);
        bit    acc_now;
        beat_t e;
        int    base;
        in_valid  = v;
        mode      = md[1:0];
        a         = va[W-1:0];
        b         = vb[W-1:0];
        clear_acc = clr;
        out_ready = ordy;
        @(negedge clk);
        check("in_ready", int'(in_ready), int'(!m_valid || ordy));
        check("acc_count", int'(acc_count), m_cnt);
        acc_now = v && (!m_valid || ordy);
        base = clr ? 0 : m_acc;
        if (clr) begin
            m_acc = 0;
            m_cnt = 0;
        end
        if (acc_now) begin
            e = model(md, va, vb, base);
            q.push_back(e);
            if (md >= 2) begin
                m_acc = e.res;
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            end
        end
        m_valid = acc_now || (m_valid && !ordy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 0;
        clear_acc = 0;
        out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        m_acc = 0;
        m_cnt = 0;
        m_valid = 0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_result", int'(result), 0);
        check("rst_carry", int'(carry), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_acc_count", int'(acc_count), 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0;
        a = 0;
        b = 0;
        mode = 0;
        clear_acc = 0;
        out_ready = 0;
        @(posedge clk);
        #1;
        do_reset();

        step(1, 0, 'hC8, 'h64, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("plan_add_res", int'(result), 'h2C);
        check("plan_add_cy", int'(carry), 1);
        step(1, 1, 'h05, 'h07, 0, 1);
        step(1, 1, 'h07, 'h05, 0, 1);
        step(1, 2, 'h80, 0, 0, 1);
        step(1, 2, 'h70, 0, 0, 1);
        step(1, 2, 'h20, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("plan_acc_res", int'(result), 'h10);
        check("plan_acc_cnt", int'(acc_count), 3);
        step(0, 0, 0, 0, 1, 1);
        step(1, 3, 'hF0, 0, 0, 1);
        step(1, 3, 'h20, 0, 0, 1);
        step(1, 3, 'h01, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("plan_sat_res", int'(result), 'hFF);
        check("plan_sat_flag", int'(sat), 1);

        step(1, 2, 'h05, 0, 0, 0);
        repeat (3) step(1, 2, 'h07, 0, 0, 0);
        check("stall_res", int'(result), 'h04);
        step(1, 2, 'h07, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        step(0, 0, 0, 0, 1, 1);
        step(1, 2, 'h40, 0, 0, 1);
        step(1, 2, 'h11, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1);
        check("plan_clr_res", int'(result), 'h11);
        check("plan_clr_cnt", int'(acc_count), 1);
        step(1, 0, 'h33, 'h44, 0, 0);
        step(1, 0, 'h01, 'h01, 0, 0);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3),
                 $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (3) step(0, 0, 0, 0, 0, 1);
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
